// File: rtl/grf_wb_arbiter_if.sv
// Bundle of register-file write-back signals: pipeline and multiply/divide
// requests, the merged write port, forwarding queries and the stall request.
interface grf_wb_arbiter_if;
    logic        p_we;
    logic [4:0]  p_rw;
    logic [31:0] p_data;
    logic [31:0] p_pc;

    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rw;
    logic [31:0] md_data;
    logic [31:0] md_pc;

    logic        grf_we;
    logic [4:0]  grf_rw;
    logic [31:0] grf_busW;
    logic [31:0] grf_pc;

    logic [4:0]  q_ra;
    logic [4:0]  q_rb;
    logic        hit_a;
    logic        hit_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    logic        pipe_stall;

    modport master (
        output p_we, p_rw, p_data, p_pc,
        output md_valid, md_rw, md_data, md_pc,
        output q_ra, q_rb,
        input  md_ready, grf_we, grf_rw, grf_busW, grf_pc,
        input  hit_a, hit_b, fwd_a, fwd_b, pipe_stall
    );

    modport slave (
        input  p_we, p_rw, p_data, p_pc,
        input  md_valid, md_rw, md_data, md_pc,
        input  q_ra, q_rb,
        output md_ready, grf_we, grf_rw, grf_busW, grf_pc,
        output hit_a, hit_b, fwd_a, fwd_b, pipe_stall
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Merges the pipeline WB stage and a queued multiply/divide unit onto the single
// register-file write port, with WAW kill, starvation stall and forwarding lookups.
module grf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             reset,
    grf_wb_arbiter_if.slave bus
);
    localparam int PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CntW    = $clog2(DEPTH) + 1;
    localparam int StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0]    FullCount = CntW'(DEPTH);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    typedef struct packed {
        logic        live;
        logic [4:0]  rw;
        logic [31:0] data;
        logic [31:0] pc;
    } entryT;

    entryT queue [DEPTH];

    logic [PtrW-1:0]    rdPtr;
    logic [PtrW-1:0]    wrPtr;
    logic [CntW-1:0]    count;
    logic [StarveW-1:0] starveCnt;
    logic [StarveW-1:0] starveNext;
    logic               pipeStall;
    logic               grfWe;
    logic [4:0]         grfRw;
    logic [31:0]        grfBusW;
    logic [31:0]        grfPc;

    logic pValid;
    logic empty;
    logic full;
    logic push;
    logic pop;

    assign pValid = bus.p_we && (bus.p_rw != 5'd0);
    assign empty  = (count == '0);
    assign full   = (count == FullCount);
    assign push   = bus.md_valid && !full;
    // The pipeline cannot be stalled at write-back, so it always owns the port.
    assign pop    = !pValid && !empty;

    assign bus.md_ready   = !full;
    assign bus.pipe_stall = pipeStall;
    assign bus.grf_we     = grfWe;
    assign bus.grf_rw     = grfRw;
    assign bus.grf_busW   = grfBusW;
    assign bus.grf_pc     = grfPc;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        starveNext = starveCnt;
        if (empty || pop) begin
            starveNext = '0;
        end else if (starveCnt != StarveMax) begin
            starveNext = starveCnt + StarveW'(1);
        end
    end

    // Output register first, then queue oldest to newest; later matches are younger and win.
    function automatic logic [32:0] lookup(input logic [4:0] r);
        logic [32:0]     res;
        logic [PtrW-1:0] idx;
        res = '0;
        if (r != 5'd0) begin
            if (grfWe && grfRw == r) res = {1'b1, grfBusW};
            for (int k = 0; k < DEPTH; k++) begin
                idx = rdPtr + PtrW'(k);
                if (CntW'(k) < count && queue[idx].live && queue[idx].rw == r) begin
                    res = {1'b1, queue[idx].data};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        {bus.hit_a, bus.fwd_a} = lookup(bus.q_ra);
        {bus.hit_b, bus.fwd_b} = lookup(bus.q_rb);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            starveCnt <= '0;
            pipeStall <= 1'b0;
            grfWe     <= 1'b0;
            grfRw     <= '0;
            grfBusW   <= '0;
            grfPc     <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PtrW'(1);
            if (pop)  rdPtr <= rdPtr + PtrW'(1);
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase

            starveCnt <= starveNext;
            pipeStall <= (starveNext == StarveMax);

            if (pValid) begin
                grfWe   <= 1'b1;
                grfRw   <= bus.p_rw;
                grfBusW <= bus.p_data;
                grfPc   <= bus.p_pc;
            end else if (!empty) begin
                grfWe   <= queue[rdPtr].live;
                grfRw   <= queue[rdPtr].rw;
                grfBusW <= queue[rdPtr].data;
                grfPc   <= queue[rdPtr].pc;
            end else begin
                grfWe   <= 1'b0;
            end
        end
    end

    // NOTE: queue storage is not reset; count gates every read, so stale slots are never observed.
    always_ff @(posedge clk) begin
        if (pValid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (queue[i].rw == bus.p_rw) queue[i].live <= 1'b0;
            end
        end
        // Issued after the kill loop so a same-cycle push is younger and stays live.
        if (push) begin
            queue[wrPtr] <= '{live: (bus.md_rw != 5'd0), rw: bus.md_rw,
                               data: bus.md_data, pc: bus.md_pc};
        end
    end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: ordering, starvation, WAW kill,
// forwarding priority, register-0 handling and mid-operation reset.
module tb_grf_wb_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    grf_wb_arbiter_if bus();

    grf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.p_we     = 1'b0;
        bus.md_valid = 1'b0;
    endtask

    task automatic pipe(input logic [4:0] rw, input logic [31:0] data, input logic [31:0] pc);
        bus.p_we   = 1'b1;
        bus.p_rw   = rw;
        bus.p_data = data;
        bus.p_pc   = pc;
    endtask

    task automatic md(input logic [4:0] rw, input logic [31:0] data, input logic [31:0] pc);
        bus.md_valid = 1'b1;
        bus.md_rw    = rw;
        bus.md_data  = data;
        bus.md_pc    = pc;
    endtask

    task automatic test_reset();
        checks++; if (bus.md_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", bus.md_ready); end
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", bus.grf_we); end
        step();
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL rst_we_idle got=%0h exp=0", bus.grf_we); end
        checks++; if (bus.grf_rw !== 5'd0) begin failures++; $display("FAIL rst_rw got=%0h exp=0", bus.grf_rw); end
        checks++; if (bus.grf_busW !== 32'h0) begin failures++; $display("FAIL rst_busW got=%0h exp=0", bus.grf_busW); end
        checks++; if (bus.grf_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%0h exp=0", bus.grf_pc); end
        checks++; if (bus.pipe_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", bus.pipe_stall); end
    endtask

    task automatic test_in_order();
        md(5'd5, 32'h11, 32'h100);
        step();
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL ord_we0 got=%0h exp=0", bus.grf_we); end
        md(5'd6, 32'h22, 32'h104);
        step();
        checks++; if (bus.grf_we !== 1'b1) begin failures++; $display("FAIL ord_we1 got=%0h exp=1", bus.grf_we); end
        checks++; if (bus.grf_rw !== 5'd5) begin failures++; $display("FAIL ord_rw1 got=%0h exp=5", bus.grf_rw); end
        checks++; if (bus.grf_busW !== 32'h11) begin failures++; $display("FAIL ord_data1 got=%0h exp=11", bus.grf_busW); end
        checks++; if (bus.grf_pc !== 32'h100) begin failures++; $display("FAIL ord_pc1 got=%0h exp=100", bus.grf_pc); end
        idle();
        step();
        checks++; if (bus.grf_we !== 1'b1) begin failures++; $display("FAIL ord_we2 got=%0h exp=1", bus.grf_we); end
        checks++; if (bus.grf_rw !== 5'd6) begin failures++; $display("FAIL ord_rw2 got=%0h exp=6", bus.grf_rw); end
        checks++; if (bus.grf_busW !== 32'h22) begin failures++; $display("FAIL ord_data2 got=%0h exp=22", bus.grf_busW); end
        checks++; if (bus.grf_pc !== 32'h104) begin failures++; $display("FAIL ord_pc2 got=%0h exp=104", bus.grf_pc); end
        step();
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL ord_we_empty got=%0h exp=0", bus.grf_we); end
        checks++; if (bus.grf_busW !== 32'h22) begin failures++; $display("FAIL ord_hold got=%0h exp=22", bus.grf_busW); end
    endtask

    task automatic test_starve();
        pipe(5'd1, 32'h50, 32'h300); md(5'd8, 32'h80, 32'h200);
        step();
        checks++; if (bus.grf_busW !== 32'h50) begin failures++; $display("FAIL stv_pipe0 got=%0h exp=50", bus.grf_busW); end
        checks++; if (bus.md_ready !== 1'b1) begin failures++; $display("FAIL stv_ready1 got=%0h exp=1", bus.md_ready); end
        pipe(5'd1, 32'h51, 32'h304); md(5'd9, 32'h90, 32'h204);
        step();
        bus.md_valid = 1'b0;
        #1;
        checks++; if (bus.md_ready !== 1'b0) begin failures++; $display("FAIL stv_full got=%0h exp=0", bus.md_ready); end
        checks++; if (bus.grf_busW !== 32'h51) begin failures++; $display("FAIL stv_pipe1 got=%0h exp=51", bus.grf_busW); end
        pipe(5'd1, 32'h52, 32'h308);
        step();
        pipe(5'd1, 32'h53, 32'h30c);
        step();
        checks++; if (bus.pipe_stall !== 1'b0) begin failures++; $display("FAIL stv_early got=%0h exp=0", bus.pipe_stall); end
        pipe(5'd1, 32'h54, 32'h310);
        step();
        checks++; if (bus.pipe_stall !== 1'b1) begin failures++; $display("FAIL stv_raise got=%0h exp=1", bus.pipe_stall); end
        pipe(5'd1, 32'h55, 32'h314);
        step();
        checks++; if (bus.grf_busW !== 32'h55) begin failures++; $display("FAIL stv_pipe_wins got=%0h exp=55", bus.grf_busW); end
        checks++; if (bus.pipe_stall !== 1'b1) begin failures++; $display("FAIL stv_sat got=%0h exp=1", bus.pipe_stall); end
        bus.p_we = 1'b0;
        md(5'd10, 32'hA0, 32'h208);
        #1;
        checks++; if (bus.md_ready !== 1'b0) begin failures++; $display("FAIL stv_full_pop got=%0h exp=0", bus.md_ready); end
        step();
        bus.md_valid = 1'b0;
        checks++; if (bus.grf_rw !== 5'd8) begin failures++; $display("FAIL stv_pop_rw got=%0h exp=8", bus.grf_rw); end
        checks++; if (bus.grf_busW !== 32'h80) begin failures++; $display("FAIL stv_pop_data got=%0h exp=80", bus.grf_busW); end
        checks++; if (bus.grf_pc !== 32'h200) begin failures++; $display("FAIL stv_pop_pc got=%0h exp=200", bus.grf_pc); end
        checks++; if (bus.pipe_stall !== 1'b0) begin failures++; $display("FAIL stv_clear got=%0h exp=0", bus.pipe_stall); end
        step();
        checks++; if (bus.grf_busW !== 32'h90) begin failures++; $display("FAIL stv_pop2 got=%0h exp=90", bus.grf_busW); end
        step();
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL stv_no_accept got=%0h exp=0", bus.grf_we); end
    endtask

    task automatic test_waw();
        md(5'd7, 32'hAA, 32'h400);
        step();
        pipe(5'd7, 32'hBB, 32'h404); md(5'd7, 32'hCC, 32'h408);
        step();
        idle();
        bus.q_ra = 5'd7;
        #1;
        checks++; if (bus.grf_busW !== 32'hBB) begin failures++; $display("FAIL waw_pipe got=%0h exp=bb", bus.grf_busW); end
        checks++; if (bus.fwd_a !== 32'hCC) begin failures++; $display("FAIL waw_fwd got=%0h exp=cc", bus.fwd_a); end
        step();
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL waw_dead got=%0h exp=0", bus.grf_we); end
        checks++; if (bus.grf_busW !== 32'hAA) begin failures++; $display("FAIL waw_dead_data got=%0h exp=aa", bus.grf_busW); end
        step();
        checks++; if (bus.grf_we !== 1'b1) begin failures++; $display("FAIL waw_young_we got=%0h exp=1", bus.grf_we); end
        checks++; if (bus.grf_busW !== 32'hCC) begin failures++; $display("FAIL waw_young got=%0h exp=cc", bus.grf_busW); end
        step();
        checks++; if (bus.hit_a !== 1'b0) begin failures++; $display("FAIL waw_nohit got=%0h exp=0", bus.hit_a); end
        checks++; if (bus.fwd_a !== 32'h0) begin failures++; $display("FAIL waw_nofwd got=%0h exp=0", bus.fwd_a); end
    endtask

    task automatic test_forward();
        pipe(5'd3, 32'h9, 32'h500); md(5'd3, 32'h1, 32'h504);
        bus.q_ra = 5'd3;
        bus.q_rb = 5'd0;
        step();
        checks++; if (bus.fwd_a !== 32'h1) begin failures++; $display("FAIL fwd_q_over_grf got=%0h exp=1", bus.fwd_a); end
        pipe(5'd4, 32'h44, 32'h508); md(5'd3, 32'h2, 32'h50c);
        step();
        idle();
        #1;
        checks++; if (bus.hit_a !== 1'b1) begin failures++; $display("FAIL fwd_hit_a got=%0h exp=1", bus.hit_a); end
        checks++; if (bus.fwd_a !== 32'h2) begin failures++; $display("FAIL fwd_newest got=%0h exp=2", bus.fwd_a); end
        checks++; if (bus.hit_b !== 1'b0) begin failures++; $display("FAIL fwd_r0_hit got=%0h exp=0", bus.hit_b); end
        checks++; if (bus.fwd_b !== 32'h0) begin failures++; $display("FAIL fwd_r0_data got=%0h exp=0", bus.fwd_b); end
        bus.q_rb = 5'd4;
        #1;
        checks++; if (bus.fwd_b !== 32'h44) begin failures++; $display("FAIL fwd_grf got=%0h exp=44", bus.fwd_b); end
        bus.q_rb = 5'd9;
        #1;
        checks++; if (bus.hit_b !== 1'b0) begin failures++; $display("FAIL fwd_miss got=%0h exp=0", bus.hit_b); end
        step();
        checks++; if (bus.fwd_a !== 32'h2) begin failures++; $display("FAIL fwd_after_pop got=%0h exp=2", bus.fwd_a); end
        step();
        step();
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL fwd_drained got=%0h exp=0", bus.grf_we); end
        bus.q_ra = 5'd0;
        bus.q_rb = 5'd0;
    endtask

    task automatic test_zero_reg();
        pipe(5'd0, 32'hDEAD, 32'h600);
        step();
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL zr_pipe_we got=%0h exp=0", bus.grf_we); end
        checks++; if (bus.grf_busW !== 32'h2) begin failures++; $display("FAIL zr_pipe_hold got=%0h exp=2", bus.grf_busW); end
        bus.p_we = 1'b0;
        md(5'd0, 32'h55, 32'h604);
        step();
        bus.md_valid = 1'b0;
        #1;
        checks++; if (bus.hit_a !== 1'b0) begin failures++; $display("FAIL zr_fwd got=%0h exp=0", bus.hit_a); end
        step();
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL zr_dead_we got=%0h exp=0", bus.grf_we); end
        checks++; if (bus.grf_busW !== 32'h55) begin failures++; $display("FAIL zr_dead_pop got=%0h exp=55", bus.grf_busW); end
    endtask

    task automatic test_mid_reset();
        pipe(5'd1, 32'h10, 32'h700); md(5'd11, 32'hB1, 32'h704);
        step();
        pipe(5'd1, 32'h12, 32'h708); md(5'd12, 32'hB2, 32'h70c);
        step();
        idle();
        #1;
        checks++; if (bus.md_ready !== 1'b0) begin failures++; $display("FAIL mr_full got=%0h exp=0", bus.md_ready); end
        reset = 1'b1;
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin failures++; $display("FAIL mr_ready got=%0h exp=1", bus.md_ready); end
        checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL mr_we got=%0h exp=0", bus.grf_we); end
        checks++; if (bus.grf_busW !== 32'h0) begin failures++; $display("FAIL mr_busW got=%0h exp=0", bus.grf_busW); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL mr_held_we got=%0h exp=0", bus.grf_we); end
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.grf_we !== 1'b0) begin failures++; $display("FAIL mr_after_we got=%0h exp=0", bus.grf_we); end
        end
        checks++; if (bus.md_ready !== 1'b1) begin failures++; $display("FAIL mr_after_ready got=%0h exp=1", bus.md_ready); end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.p_we     = 1'b0;
        bus.p_rw     = '0;
        bus.p_data   = '0;
        bus.p_pc     = '0;
        bus.md_valid = 1'b0;
        bus.md_rw    = '0;
        bus.md_data  = '0;
        bus.md_pc    = '0;
        bus.q_ra     = '0;
        bus.q_rb     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        test_reset();
        test_in_order();
        test_starve();
        test_waw();
        test_forward();
        test_zero_reg();
        test_mid_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
